mvm_output_buffer: RTL

- Downstream stage of the matrix-vector multiply control/datapath.
- Accepts one accumulated result per valid/ready handshake from the accumulator (the MVM output_valid/output_ready pair) and buffers up to DEPTH results in a first-word-fall-through FIFO.
- Optionally applies signed ReLU on write and tags the M-th result of each output vector with out_last.
- Decouples the MVM compute loop from a stalling consumer.

---
 rtl/mvm_output_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/mvm_output_buffer.sv
// Output FIFO for the matrix-vector multiplier: buffers accumulated results,
// optionally clamps negatives to zero and tags the last element of each vector.
module mvm_output_buffer #(
    parameter int unsigned M     = 12,
    parameter int unsigned W     = 28,
    parameter int unsigned DEPTH = 4,
    parameter bit          RELU  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [W-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;

    logic [W:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] idx_q, idx_d;
    // Holds in_ready low until the first edge after reset release.
    logic            run_q;

    logic            push;
    logic            pop;
    logic            last_flag;
    logic [W-1:0]    wr_data;

    always_comb begin
        in_ready  = run_q && (count_q < CntW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        last_flag = (idx_q == IdxW'(M - 1));
        wr_data   = (RELU && in_data[W-1]) ? '0 : in_data;

        out_data  = out_valid ? mem_q[rd_ptr_q][W-1:0] : '0;
        out_last  = out_valid ? mem_q[rd_ptr_q][W] : 1'b0;
        count     = count_q;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        count_d   = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            idx_d    = last_flag ? '0 : idx_q + IdxW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            run_q    <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; out_valid gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {last_flag, wr_data};
        end
    end

endmodule
